// File: rtl/dds_spi_pkg.sv
// Shared definitions for the DDS SPI control path (spi_cmd_tx, spi_in, cmd_decoder).
package dds_spi_pkg;

  localparam int CMD_WIDTH    = 8;
  localparam int DATA_WIDTH   = 16;
  localparam int PACKET_WIDTH = CMD_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO queuing packets in front of the SPI shifter.
module spi_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)
        count_q <= count_q + 1'b1;
      else if (do_pop && !do_push)
        count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_cmd_tx.sv
// Host-side SPI mode-0 transmitter: {cmd, data} words become 24-bit packets, MSB first.
// Optional input queue enabled by defining SPI_CMD_TX_FIFO_EN.
module spi_cmd_tx
  import dds_spi_pkg::*;
#(
  parameter int CMD_WIDTH    = dds_spi_pkg::CMD_WIDTH,
  parameter int DATA_WIDTH   = dds_spi_pkg::DATA_WIDTH,
  parameter int PACKET_WIDTH = CMD_WIDTH + DATA_WIDTH,
  parameter int CLK_DIV      = 4,
  parameter int CSB_GAP      = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CMD_WIDTH-1:0]  in_cmd,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);

  localparam int DIV_MAX = (CLK_DIV > CSB_GAP) ? CLK_DIV : CSB_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int BIT_W   = $clog2(PACKET_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END = DIV_W'(CSB_GAP - 1);

  spi_state_e               state_q;
  // Upper field: bits still to send; lower field: cycles spent in the current phase.
  logic [BIT_W+DIV_W-1:0]   cnt_q;
  logic [BIT_W-1:0]         bits;
  logic [DIV_W-1:0]         div;
  logic [PACKET_WIDTH-1:0]  shift_q;
  logic                     sclk_q, mosi_q, csb_q, busy_q, rdy_q;
  logic [PACKET_WIDTH-1:0]  head_pkt;
  logic                     start;
  logic                     pending;

  assign {bits, div} = cnt_q;

`ifdef SPI_CMD_TX_FIFO_EN
  logic fifo_full, fifo_empty, fifo_push;

  assign fifo_push = in_valid && !fifo_full;
  assign in_ready  = !fifo_full;
  assign start     = (state_q == IDLE) && !fifo_empty;
  assign pending   = !fifo_empty || fifo_push;

  spi_cmd_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({in_cmd, in_data}),
    .pop_i   (start),
    .rdata_o (head_pkt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  assign in_ready = rdy_q;
  assign head_pkt = {in_cmd, in_data};
  assign start    = in_valid && rdy_q;
  assign pending  = 1'b0;
`endif

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign csb  = csb_q;
  assign busy = busy_q;

  // Packet sequencer: every output is set on the transition into the state that owns it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csb_q   <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= head_pkt;
            mosi_q  <= head_pkt[PACKET_WIDTH-1];
            csb_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= {BIT_W'(PACKET_WIDTH), {DIV_W{1'b0}}};
            state_q <= SETUP;
          end else begin
            busy_q  <= pending;
          end
        end
        SETUP, LOW: begin
          if (div == DIV_END) begin
            cnt_q   <= {bits, {DIV_W{1'b0}}};
            sclk_q  <= 1'b1;
            state_q <= HIGH;
          end else begin
            cnt_q   <= {bits, div + 1'b1};
          end
        end
        HIGH: begin
          if (div == DIV_END) begin
            cnt_q  <= {bits - 1'b1, {DIV_W{1'b0}}};
            sclk_q <= 1'b0;
            if (bits != BIT_W'(1)) begin
              shift_q <= shift_q << 1;
              mosi_q  <= shift_q[PACKET_WIDTH-2];
              state_q <= LOW;
            end else begin
              state_q <= HOLD;
            end
          end else begin
            cnt_q <= {bits, div + 1'b1};
          end
        end
        HOLD: begin
          if (div == DIV_END) begin
            cnt_q   <= '0;
            csb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= {bits, div + 1'b1};
          end
        end
        GAP: begin
          if (div == GAP_END) begin
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= pending;
            state_q <= IDLE;
          end else begin
            cnt_q <= {bits, div + 1'b1};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Directed bench for spi_cmd_tx (default build, no input queue).
module tb_spi_cmd_tx;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_cmd  = '0;
  logic [15:0] in_data = '0;
  logic        busy, sclk, mosi, csb;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  spi_cmd_tx #(
    .CLK_DIV (4),
    .CSB_GAP (8)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .in_data  (in_data),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .csb      (csb)
  );

  // Receiver model: shift mosi in on each sclk rise.
  int          rises = 0;
  logic [23:0] cap   = '0;
  always @(posedge sclk) begin
    if (rst_n) begin
      rises = rises + 1;
      cap   = {cap[22:0], mosi};
    end
  end

  // csb-low cycle count and length of the most recent csb-high run.
  int low_cyc  = 0;
  int hi_run   = 0;
  int last_gap = 0;
  always @(negedge sys_clk) begin
    if (csb === 1'b0) begin
      low_cyc = low_cyc + 1;
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run = hi_run + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      @(posedge sys_clk); #1;
      n++;
    end
  endtask

  initial begin
    int n, r0, l0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_csb", csb, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_ready", in_ready, 1);

    // Single packet 0x01 / 0x1234
    r0 = rises; l0 = low_cyc;
    @(negedge sys_clk);
    in_cmd = 8'h01; in_data = 16'h1234; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    chk("t1_csb_low", csb, 0);
    chk("t1_ready_low", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_sclk_setup", sclk, 0);
    wait_ready(n);
    chk("t1_ready_latency", n, 204);
    chk("t1_rises", rises - r0, 24);
    chk("t1_word", cap, 24'h011234);
    chk("t1_csb_cycles", low_cyc - l0, 196);
    chk("t1_busy_done", busy, 0);

    // Inputs scrambled every cycle after the handshake
    r0 = rises;
    @(negedge sys_clk);
    in_cmd = 8'hC3; in_data = 16'h0F0F; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    chk("stab_mosi_msb", mosi, 1);
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      @(negedge sys_clk);
      in_cmd  = 8'($urandom);
      in_data = 16'($urandom);
      @(posedge sys_clk); #1;
      n++;
    end
    chk("stab_latency", n, 204);
    chk("stab_rises", rises - r0, 24);
    chk("stab_word", cap, 24'hC30F0F);

    // Back-to-back with in_valid held high
    r0 = rises;
    @(negedge sys_clk);
    in_cmd = 8'hA5; in_data = 16'h5AC3; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_cmd = 8'h3C; in_data = 16'hFFFF;
    wait_ready(n);
    chk("b2b_ready_latency", n, 204);
    chk("b2b_word1", cap, 24'hA55AC3);
    chk("b2b_rises1", rises - r0, 24);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    chk("b2b_second_accept_ready", in_ready, 0);
    chk("b2b_second_accept_csb", csb, 0);
    chk("b2b_second_mosi", mosi, 0);
    wait_ready(n);
    chk("b2b_ready_latency2", n, 204);
    chk("b2b_gap", last_gap, 9);
    chk("b2b_word2", cap, 24'h3CFFFF);
    chk("b2b_rises2", rises - r0, 48);

    // Reset after the 10th sclk rise
    r0 = rises;
    @(negedge sys_clk);
    in_cmd = 8'hFF; in_data = 16'hFFFF; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while ((rises - r0) < 10 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("mid_rise10", rises - r0, 10);
    chk("mid_pre_sclk", sclk, 1);
    chk("mid_pre_mosi", mosi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_csb", csb, 1);
    chk("mid_sclk", sclk, 0);
    chk("mid_mosi", mosi, 0);
    chk("mid_busy", busy, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    r0 = rises; l0 = low_cyc;
    @(negedge sys_clk);
    chk("mid_ready_after", in_ready, 1);
    repeat (300) @(negedge sys_clk);
    chk("mid_no_rises", rises - r0, 0);
    chk("mid_no_csb", low_cyc - l0, 0);
    chk("mid_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
